// File: rtl/cm3_reset_ctrl.sv
// CM3 reset and power-up sequencer: PLL-lock gated PORESETn/CPURESETn ordering, SYSRESETREQ handling,
// debug power-up handshake and reset-cause capture. Optional lockup reset under CM3_RSTCTRL_LOCKUP_EN.
module cm3_reset_ctrl #(
    parameter int unsigned POR_CYCLES    = 245,
    parameter int unsigned CPU_DELAY     = 10,
    parameter int unsigned SYSRST_CYCLES = 16,
    parameter int unsigned PWRUP_DELAY   = 4
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       PLL_LOCKED,
    input  logic       SYSRESETREQ,
`ifdef CM3_RSTCTRL_LOCKUP_EN
    input  logic       LOCKUP,
`endif
    input  logic       CDBGPWRUPREQ,
    output logic       CDBGPWRUPACK,
    output logic       PORESETn,
    output logic       CPURESETn,
    output logic [3:0] RST_CAUSE,
    output logic       BUSY
);

    localparam int unsigned MAX_A   = (POR_CYCLES > CPU_DELAY) ? POR_CYCLES : CPU_DELAY;
    localparam int unsigned CNT_MAX = (MAX_A > SYSRST_CYCLES) ? MAX_A : SYSRST_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned PW      = $clog2(PWRUP_DELAY + 1);

    localparam logic [3:0] CAUSE_PIN    = 4'b0001;
    localparam logic [3:0] CAUSE_PLL    = 4'b0010;
    localparam logic [3:0] CAUSE_SYSREQ = 4'b0100;
    localparam logic [3:0] CAUSE_LOCKUP = 4'b1000;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_POR_HOLD,
        ST_CPU_HOLD,
        ST_RUN,
        ST_SYS_RST
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      cause_q, cause_d;
    logic            sync1_q, lock_s_q;
    logic            por_q, por_d, cpu_q, cpu_d, busy_q, busy_d;
    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic            ack_q, ack_d;
    logic            lk_hit;

    // PLL_LOCKED is asynchronous to CLK
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= PLL_LOCKED;
            lock_s_q <= sync1_q;
        end
    end

`ifdef CM3_RSTCTRL_LOCKUP_EN
    logic [9:0] lk_cnt_q, lk_cnt_d;

    assign lk_hit = LOCKUP && (lk_cnt_q == 10'h3FF);

    always_comb begin
        lk_cnt_d = '0;
        if ((state_q == ST_RUN) && (state_d == ST_RUN) && LOCKUP) begin
            lk_cnt_d = lk_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) lk_cnt_q <= '0;
        else         lk_cnt_q <= lk_cnt_d;
    end
`else
    assign lk_hit = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
            cause_q <= CAUSE_PIN;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Lock loss overrides every other transition
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        if ((state_q != ST_WAIT_LOCK) && !lock_s_q) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            cause_d = CAUSE_PLL;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_d = ST_POR_HOLD;
                        cnt_d   = CW'(POR_CYCLES - 1);
                    end
                end
                ST_POR_HOLD: begin
                    if (cnt_q == '0) begin
                        state_d = ST_CPU_HOLD;
                        cnt_d   = CW'(CPU_DELAY - 1);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_CPU_HOLD: begin
                    if (cnt_q == '0) state_d = ST_RUN;
                    else             cnt_d   = cnt_q - CW'(1);
                end
                ST_RUN: begin
                    if (SYSRESETREQ) begin
                        state_d = ST_SYS_RST;
                        cnt_d   = CW'(SYSRST_CYCLES - 1);
                        cause_d = CAUSE_SYSREQ;
                    end else if (lk_hit) begin
                        state_d = ST_SYS_RST;
                        cnt_d   = CW'(SYSRST_CYCLES - 1);
                        cause_d = CAUSE_LOCKUP;
                    end
                end
                ST_SYS_RST: begin
                    if (cnt_q != '0)       cnt_d   = cnt_q - CW'(1);
                    else if (!SYSRESETREQ) state_d = ST_RUN;
                end
                default: state_d = ST_WAIT_LOCK;
            endcase
        end
    end

    // Output decode from next state so the registered outputs track the state register
    always_comb begin
        por_d  = 1'b1;
        cpu_d  = 1'b0;
        busy_d = 1'b1;
        case (state_d)
            ST_WAIT_LOCK, ST_POR_HOLD: por_d = 1'b0;
            ST_RUN: begin
                cpu_d  = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            por_q  <= 1'b0;
            cpu_q  <= 1'b0;
            busy_q <= 1'b1;
        end else begin
            por_q  <= por_d;
            cpu_q  <= cpu_d;
            busy_q <= busy_d;
        end
    end

    // Debug power-up: request counts only once PORESETn is already high; power-on reset clears it
    always_comb begin
        pcnt_d = '0;
        ack_d  = 1'b0;
        if (por_d && por_q && CDBGPWRUPREQ) begin
            ack_d  = ack_q || (pcnt_q == PW'(PWRUP_DELAY - 1));
            pcnt_d = ack_d ? pcnt_q : pcnt_q + PW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            pcnt_q <= '0;
            ack_q  <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            ack_q  <= ack_d;
        end
    end

    assign PORESETn     = por_q;
    assign CPURESETn    = cpu_q;
    assign BUSY         = busy_q;
    assign CDBGPWRUPACK = ack_q;
    assign RST_CAUSE    = cause_q;

endmodule

// File: tb/tb_cm3_reset_ctrl.sv
// Self-checking bench for cm3_reset_ctrl; output transitions are scored against a queue of expected
// (signal, value, edge) events. Build with CM3_RSTCTRL_LOCKUP_EN to include the lockup scenario.
module tb_cm3_reset_ctrl;

    localparam int SIG_POR  = 0;
    localparam int SIG_ACK  = 1;
    localparam int SIG_CPU  = 2;
    localparam int SIG_BUSY = 3;

    typedef struct {
        int          id;
        logic        val;
        int unsigned edge_no;
    } ev_t;

    logic       CLK = 1'b0;
    logic       RESETn, PLL_LOCKED, SYSRESETREQ, CDBGPWRUPREQ;
`ifdef CM3_RSTCTRL_LOCKUP_EN
    logic       LOCKUP;
`endif
    logic       CDBGPWRUPACK, PORESETn, CPURESETn, BUSY;
    logic [3:0] RST_CAUSE;

    ev_t         exp_q[$];
    int unsigned edge_n = 0;
    int          n_cmp  = 0;
    int          n_fail = 0;
    bit          sb_on  = 1'b0;
    logic [3:0]  prev_v = 4'bxxxx;

    cm3_reset_ctrl dut (
        .CLK          (CLK),
        .RESETn       (RESETn),
        .PLL_LOCKED   (PLL_LOCKED),
        .SYSRESETREQ  (SYSRESETREQ),
`ifdef CM3_RSTCTRL_LOCKUP_EN
        .LOCKUP       (LOCKUP),
`endif
        .CDBGPWRUPREQ (CDBGPWRUPREQ),
        .CDBGPWRUPACK (CDBGPWRUPACK),
        .PORESETn     (PORESETn),
        .CPURESETn    (CPURESETn),
        .RST_CAUSE    (RST_CAUSE),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at edge %0d, required finish before it", edge_n);
        $fatal(1, "watchdog expired");
    end

    function automatic string sig_name(input int k);
        case (k)
            SIG_POR: return "PORESETn";
            SIG_ACK: return "CDBGPWRUPACK";
            SIG_CPU: return "CPURESETn";
            default: return "BUSY";
        endcase
    endfunction

    task automatic push_ev(input int id, input logic v, input int unsigned e);
        ev_t x;
        x.id      = id;
        x.val     = v;
        x.edge_no = e;
        exp_q.push_back(x);
    endtask

    // One clock: sample 1 after the edge, score any output transition, leave inputs free to change
    task automatic tick();
        ev_t        e;
        logic [3:0] cur_v;
        @(posedge CLK);
        edge_n++;
        #1;
        cur_v = {BUSY, CPURESETn, CDBGPWRUPACK, PORESETn};
        if (sb_on) begin
            for (int k = 0; k < 4; k++) begin
                if (cur_v[k] !== prev_v[k]) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_event: got %s->%b at edge %0d, required no change",
                                 sig_name(k), cur_v[k], edge_n);
                    end else begin
                        e = exp_q.pop_front();
                        if ((e.id != k) || (e.val !== cur_v[k]) || (e.edge_no != edge_n)) begin
                            n_fail++;
                            $display("FAIL event: got %s->%b at edge %0d, required %s->%b at edge %0d",
                                     sig_name(k), cur_v[k], edge_n, sig_name(e.id), e.val, e.edge_no);
                        end
                    end
                end
            end
        end
        prev_v = cur_v;
        #1;
    endtask

    task automatic check_pending(input string tname);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: %0d expected events not seen, required 0 (next %s->%b at edge %0d)",
                     tname, exp_q.size(), sig_name(exp_q[0].id), exp_q[0].val, exp_q[0].edge_no);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        RESETn       = 1'b0;
        PLL_LOCKED   = 1'b0;
        SYSRESETREQ  = 1'b0;
        CDBGPWRUPREQ = 1'b0;
`ifdef CM3_RSTCTRL_LOCKUP_EN
        LOCKUP       = 1'b0;
`endif
        repeat (5) tick();
        n_cmp++; if (PORESETn !== 1'b0)    begin n_fail++; $display("FAIL reset_poresetn: got %b required 0", PORESETn); end
        n_cmp++; if (CPURESETn !== 1'b0)   begin n_fail++; $display("FAIL reset_cpuresetn: got %b required 0", CPURESETn); end
        n_cmp++; if (CDBGPWRUPACK !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b required 0", CDBGPWRUPACK); end
        n_cmp++; if (BUSY !== 1'b1)        begin n_fail++; $display("FAIL reset_busy: got %b required 1", BUSY); end
        n_cmp++; if (RST_CAUSE !== 4'b0001) begin n_fail++; $display("FAIL reset_cause: got %b required 0001", RST_CAUSE); end
        sb_on = 1'b1;
    endtask

    // Debug request is already high while PORESETn is low; ACK must wait for PORESETn
    task automatic test_power_up();
        int unsigned t0;
        t0 = edge_n;
        RESETn       = 1'b1;
        PLL_LOCKED   = 1'b1;
        CDBGPWRUPREQ = 1'b1;
        push_ev(SIG_POR, 1'b1, t0 + 248);
        push_ev(SIG_ACK, 1'b1, t0 + 252);
        push_ev(SIG_CPU, 1'b1, t0 + 258);
        push_ev(SIG_BUSY, 1'b0, t0 + 258);
        repeat (250) tick();
        n_cmp++; if (CDBGPWRUPACK !== 1'b0) begin n_fail++; $display("FAIL pwrup_ack_early: got %b required 0", CDBGPWRUPACK); end
        repeat (12) tick();
        n_cmp++; if (RST_CAUSE !== 4'b0001) begin n_fail++; $display("FAIL pwrup_cause: got %b required 0001", RST_CAUSE); end
        n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL pwrup_busy: got %b required 0", BUSY); end
        check_pending("power_up");
    endtask

    task automatic test_sysreset_pulse();
        int unsigned t0;
        t0 = edge_n;
        SYSRESETREQ = 1'b1;
        push_ev(SIG_CPU, 1'b0, t0 + 1);
        push_ev(SIG_BUSY, 1'b1, t0 + 1);
        push_ev(SIG_CPU, 1'b1, t0 + 17);
        push_ev(SIG_BUSY, 1'b0, t0 + 17);
        tick();
        SYSRESETREQ = 1'b0;
        repeat (8) tick();
        n_cmp++; if (RST_CAUSE !== 4'b0100) begin n_fail++; $display("FAIL sysrst_cause: got %b required 0100", RST_CAUSE); end
        n_cmp++; if (PORESETn !== 1'b1) begin n_fail++; $display("FAIL sysrst_poresetn: got %b required 1", PORESETn); end
        n_cmp++; if (CDBGPWRUPACK !== 1'b1) begin n_fail++; $display("FAIL sysrst_ack: got %b required 1", CDBGPWRUPACK); end
        repeat (12) tick();
        check_pending("sysreset_pulse");
    endtask

    task automatic test_sysreset_hold();
        int unsigned t0;
        t0 = edge_n;
        SYSRESETREQ = 1'b1;
        push_ev(SIG_CPU, 1'b0, t0 + 1);
        push_ev(SIG_BUSY, 1'b1, t0 + 1);
        push_ev(SIG_CPU, 1'b1, t0 + 31);
        push_ev(SIG_BUSY, 1'b0, t0 + 31);
        repeat (30) tick();
        SYSRESETREQ = 1'b0;
        repeat (5) tick();
        n_cmp++; if (RST_CAUSE !== 4'b0100) begin n_fail++; $display("FAIL sysrst_hold_cause: got %b required 0100", RST_CAUSE); end
        check_pending("sysreset_hold");
    endtask

    task automatic test_lock_loss_run();
        int unsigned t0, t1;
        t0 = edge_n;
        PLL_LOCKED = 1'b0;
        push_ev(SIG_POR, 1'b0, t0 + 3);
        push_ev(SIG_ACK, 1'b0, t0 + 3);
        push_ev(SIG_CPU, 1'b0, t0 + 3);
        push_ev(SIG_BUSY, 1'b1, t0 + 3);
        repeat (6) tick();
        n_cmp++; if (RST_CAUSE !== 4'b0010) begin n_fail++; $display("FAIL lockloss_cause: got %b required 0010", RST_CAUSE); end
        t1 = edge_n;
        PLL_LOCKED = 1'b1;
        push_ev(SIG_POR, 1'b1, t1 + 248);
        push_ev(SIG_ACK, 1'b1, t1 + 252);
        push_ev(SIG_CPU, 1'b1, t1 + 258);
        push_ev(SIG_BUSY, 1'b0, t1 + 258);
        repeat (262) tick();
        n_cmp++; if (RST_CAUSE !== 4'b0010) begin n_fail++; $display("FAIL relock_cause: got %b required 0010", RST_CAUSE); end
        check_pending("lock_loss_run");
    endtask

    task automatic test_lock_loss_sysrst();
        int unsigned t0, t1;
        t0 = edge_n;
        SYSRESETREQ = 1'b1;
        push_ev(SIG_CPU, 1'b0, t0 + 1);
        push_ev(SIG_BUSY, 1'b1, t0 + 1);
        repeat (5) tick();
        t1 = edge_n;
        PLL_LOCKED = 1'b0;
        push_ev(SIG_POR, 1'b0, t1 + 3);
        push_ev(SIG_ACK, 1'b0, t1 + 3);
        repeat (3) tick();
        n_cmp++; if (RST_CAUSE !== 4'b0010) begin n_fail++; $display("FAIL sysrst_lockloss_cause: got %b required 0010", RST_CAUSE); end
        SYSRESETREQ = 1'b0;
        repeat (3) tick();
        check_pending("lock_loss_sysrst");
    endtask

    // RESETn during CPU_HOLD, then a full restart with SYSRESETREQ asserted during the hold states
    task automatic test_reset_mid_cpu_hold();
        int unsigned t0, t1;
        t0 = edge_n;
        PLL_LOCKED = 1'b1;
        push_ev(SIG_POR, 1'b1, t0 + 248);
        repeat (250) tick();
        RESETn = 1'b0;
        push_ev(SIG_POR, 1'b0, t0 + 251);
        tick();
        n_cmp++; if (PORESETn !== 1'b0)    begin n_fail++; $display("FAIL midrst_poresetn: got %b required 0", PORESETn); end
        n_cmp++; if (CPURESETn !== 1'b0)   begin n_fail++; $display("FAIL midrst_cpuresetn: got %b required 0", CPURESETn); end
        n_cmp++; if (CDBGPWRUPACK !== 1'b0) begin n_fail++; $display("FAIL midrst_ack: got %b required 0", CDBGPWRUPACK); end
        n_cmp++; if (BUSY !== 1'b1)        begin n_fail++; $display("FAIL midrst_busy: got %b required 1", BUSY); end
        n_cmp++; if (RST_CAUSE !== 4'b0001) begin n_fail++; $display("FAIL midrst_cause: got %b required 0001", RST_CAUSE); end
        repeat (2) tick();
        t1 = edge_n;
        RESETn = 1'b1;
        push_ev(SIG_POR, 1'b1, t1 + 248);
        push_ev(SIG_ACK, 1'b1, t1 + 252);
        push_ev(SIG_CPU, 1'b1, t1 + 258);
        push_ev(SIG_BUSY, 1'b0, t1 + 258);
        for (int i = 1; i <= 262; i++) begin
            tick();
            if (i == 19)  SYSRESETREQ = 1'b1;
            if (i == 255) SYSRESETREQ = 1'b0;
        end
        n_cmp++; if (RST_CAUSE !== 4'b0001) begin n_fail++; $display("FAIL restart_cause: got %b required 0001", RST_CAUSE); end
        check_pending("reset_mid_cpu_hold");
    endtask

    task automatic test_debug_handshake();
        int unsigned t0, t2;
        t0 = edge_n;
        CDBGPWRUPREQ = 1'b0;
        push_ev(SIG_ACK, 1'b0, t0 + 1);
        repeat (3) tick();
        CDBGPWRUPREQ = 1'b1;
        repeat (2) tick();
        CDBGPWRUPREQ = 1'b0;
        repeat (6) tick();
        n_cmp++; if (CDBGPWRUPACK !== 1'b0) begin n_fail++; $display("FAIL short_req_ack: got %b required 0", CDBGPWRUPACK); end
        t2 = edge_n;
        CDBGPWRUPREQ = 1'b1;
        push_ev(SIG_ACK, 1'b1, t2 + 4);
        repeat (3) tick();
        n_cmp++; if (CDBGPWRUPACK !== 1'b0) begin n_fail++; $display("FAIL req_delay_ack: got %b required 0", CDBGPWRUPACK); end
        repeat (3) tick();
        n_cmp++; if (CDBGPWRUPACK !== 1'b1) begin n_fail++; $display("FAIL req_ack: got %b required 1", CDBGPWRUPACK); end
        check_pending("debug_handshake");
    endtask

`ifdef CM3_RSTCTRL_LOCKUP_EN
    task automatic test_lockup();
        int unsigned t1, t2;
        LOCKUP = 1'b1;
        repeat (1023) tick();
        LOCKUP = 1'b0;
        repeat (4) tick();
        n_cmp++; if (CPURESETn !== 1'b1) begin n_fail++; $display("FAIL lockup_1023_cpuresetn: got %b required 1", CPURESETn); end
        t1 = edge_n;
        LOCKUP = 1'b1;
        push_ev(SIG_CPU, 1'b0, t1 + 1024);
        push_ev(SIG_BUSY, 1'b1, t1 + 1024);
        push_ev(SIG_CPU, 1'b1, t1 + 1040);
        push_ev(SIG_BUSY, 1'b0, t1 + 1040);
        repeat (1024) tick();
        LOCKUP = 1'b0;
        n_cmp++; if (RST_CAUSE !== 4'b1000) begin n_fail++; $display("FAIL lockup_cause: got %b required 1000", RST_CAUSE); end
        repeat (20) tick();
        t2 = edge_n;
        LOCKUP = 1'b1;
        push_ev(SIG_CPU, 1'b0, t2 + 1024);
        push_ev(SIG_BUSY, 1'b1, t2 + 1024);
        push_ev(SIG_CPU, 1'b1, t2 + 1040);
        push_ev(SIG_BUSY, 1'b0, t2 + 1040);
        repeat (1023) tick();
        SYSRESETREQ = 1'b1;
        tick();
        SYSRESETREQ = 1'b0;
        LOCKUP      = 1'b0;
        n_cmp++; if (RST_CAUSE !== 4'b0100) begin n_fail++; $display("FAIL lockup_sysreq_cause: got %b required 0100", RST_CAUSE); end
        repeat (20) tick();
        check_pending("lockup");
    endtask
`endif

    initial begin
        test_reset();
        test_power_up();
        test_sysreset_pulse();
        test_sysreset_hold();
        test_lock_loss_run();
        test_lock_loss_sysrst();
        test_reset_mid_cpu_hold();
        test_debug_handshake();
`ifdef CM3_RSTCTRL_LOCKUP_EN
        test_lockup();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
